pong_ball_ctrl: RTL and testbench

Per-frame game sequencer for the pong display pipeline. It owns the ball position and direction and advances them once per frame, during vertical blanking. It bounces the ball off the top, bottom and right walls and off the player paddle on the left, and signals a miss. ball_x/ball_y are active-area coordinates (0,0 = first visible pixel), consumed by the drawing logic for pixel compares.

---
 rtl/pong_pkg.sv | 34 +++
 rtl/pong_axis_step.sv | 53 +++++
 rtl/pong_ball_ctrl.sv | 148 ++++++++++++++
 tb/tb_pong_ball_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module : pong_pkg
// Brief  : Shared state encoding, direction type and default geometry for pong.
// Rev    : 1.0
// ============================================================================
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    WAIT   = 3'd2,
    MOVE_X = 3'd3,
    MOVE_Y = 3'd4,
    MISS   = 3'd5
  } state_t;

  // 0 = towards larger coordinates, 1 = towards smaller coordinates
  typedef logic dir_t;
  localparam dir_t DIR_POS = 1'b0;
  localparam dir_t DIR_NEG = 1'b1;

  localparam int DEF_CORDW        = 10;
  localparam int DEF_H_RES        = 640;
  localparam int DEF_V_RES        = 480;
  localparam int DEF_BALL_SIZE    = 8;
  localparam int DEF_BALL_SPEED   = 2;
  localparam int DEF_PAD_X        = 16;
  localparam int DEF_PAD_W        = 8;
  localparam int DEF_PAD_H        = 64;
  localparam int DEF_SERVE_FRAMES = 60;

endpackage
`default_nettype wire

// File: rtl/pong_axis_step.sv
`default_nettype none
// ============================================================================
// Module : pong_axis_step
// Brief  : One-axis position step with clamp and bounce at both limits.
// Rev    : 1.0
// ============================================================================
module pong_axis_step
  import pong_pkg::*;
#(
  parameter int W    = 10,
  parameter int STEP = 2
) (
  input  logic [W-1:0] pos_i,
  input  dir_t         dir_i,
  input  logic [W-1:0] lo_i,
  input  logic [W-1:0] hi_i,
  output logic [W-1:0] pos_o,
  output dir_t         dir_o,
  output logic         at_lo_o
);

  logic [W:0] pos_w;
  logic [W:0] lo_lim;
  logic [W:0] hi_lim;

  // Limits are tested before stepping so a decrement never wraps.
  always_comb begin
    pos_w   = {1'b0, pos_i};
    lo_lim  = {1'b0, lo_i} + (W+1)'(STEP);
    hi_lim  = {1'b0, hi_i} - (W+1)'(STEP);
    pos_o   = pos_i;
    dir_o   = dir_i;
    at_lo_o = 1'b0;
    if (dir_i == DIR_POS) begin
      if (pos_w >= hi_lim) begin
        pos_o = hi_i;
        dir_o = DIR_NEG;
      end else begin
        pos_o = W'(pos_w + (W+1)'(STEP));
      end
    end else begin
      if (pos_w <= lo_lim) begin
        pos_o   = lo_i;
        dir_o   = DIR_POS;
        at_lo_o = 1'b1;
      end else begin
        pos_o = W'(pos_w - (W+1)'(STEP));
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pong_ball_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pong_ball_ctrl
// Brief  : Per-frame ball sequencer: serve delay, wall/paddle bounce, miss.
// Rev    : 1.0
// ============================================================================
module pong_ball_ctrl
  import pong_pkg::*;
#(
  parameter int CORDW        = DEF_CORDW,
  parameter int H_RES        = DEF_H_RES,
  parameter int V_RES        = DEF_V_RES,
  parameter int BALL_SIZE    = DEF_BALL_SIZE,
  parameter int BALL_SPEED   = DEF_BALL_SPEED,
  parameter int PAD_X        = DEF_PAD_X,
  parameter int PAD_W        = DEF_PAD_W,
  parameter int PAD_H        = DEF_PAD_H,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES
) (
  input  logic             pix_clk,
  input  logic             rst_pix_n,
  input  logic             frame,
  input  logic             start,
  input  logic [CORDW-1:0] paddle_y,
  output logic [CORDW-1:0] ball_x,
  output logic [CORDW-1:0] ball_y,
  output logic             ball_valid,
  output logic             miss,
  output logic             busy
);

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
  localparam logic [CORDW-1:0] C_X_CTR = CORDW'((H_RES - BALL_SIZE) / 2);
  localparam logic [CORDW-1:0] C_Y_CTR = CORDW'((V_RES - BALL_SIZE) / 2);
  localparam logic [CORDW-1:0] C_X_HI  = CORDW'(H_RES - BALL_SIZE);
  localparam logic [CORDW-1:0] C_X_LO  = CORDW'(PAD_X + PAD_W);
  localparam logic [CORDW-1:0] C_Y_HI  = CORDW'(V_RES - BALL_SIZE);
  localparam logic [CORDW-1:0] C_Y_LO  = '0;
  localparam logic [CNT_W-1:0] C_SERVE = CNT_W'(SERVE_FRAMES);

  state_t             state_q, state_d;
  logic [CORDW-1:0]   ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  dir_t               dx_q, dx_d, dy_q, dy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, miss_q, busy_q;

  logic [CORDW-1:0]   x_step, y_step;
  dir_t               dx_step, dy_step;
  logic               x_at_lo, y_at_lo;
  logic               hit;

  pong_axis_step #(.W(CORDW), .STEP(BALL_SPEED)) u_step_x (
    .pos_i(ball_x_q), .dir_i(dx_q), .lo_i(C_X_LO), .hi_i(C_X_HI),
    .pos_o(x_step), .dir_o(dx_step), .at_lo_o(x_at_lo)
  );

  pong_axis_step #(.W(CORDW), .STEP(BALL_SPEED)) u_step_y (
    .pos_i(ball_y_q), .dir_i(dy_q), .lo_i(C_Y_LO), .hi_i(C_Y_HI),
    .pos_o(y_step), .dir_o(dy_step), .at_lo_o(y_at_lo)
  );

  // Paddle overlap uses the pre-move ball_y, since X is stepped before Y.
  assign hit = ({1'b0, paddle_y} < ({1'b0, ball_y_q} + (CORDW+1)'(BALL_SIZE))) &&
               ({1'b0, ball_y_q} < ({1'b0, paddle_y} + (CORDW+1)'(PAD_H)));

  always_comb begin
    state_d  = state_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d    = C_SERVE;
          ball_x_d = C_X_CTR;
          ball_y_d = C_Y_CTR;
          state_d  = SERVE;
        end
      end
      SERVE: begin
        if (frame) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = WAIT;
        end
      end
      WAIT: begin
        if (frame) state_d = MOVE_X;
      end
      MOVE_X: begin
        if (x_at_lo && !hit) begin
          state_d = MISS;
        end else begin
          ball_x_d = x_step;
          dx_d     = dx_step;
          state_d  = MOVE_Y;
        end
      end
      MOVE_Y: begin
        ball_y_d = y_step;
        dy_d     = y_at_lo ? DIR_POS : dy_step;
        state_d  = WAIT;
      end
      MISS: begin
        ball_x_d = C_X_CTR;
        ball_y_d = C_Y_CTR;
        dx_d     = DIR_POS;
        cnt_d    = C_SERVE;
        state_d  = SERVE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with state_q.
  always_ff @(posedge pix_clk or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state_q  <= IDLE;
      ball_x_q <= C_X_CTR;
      ball_y_q <= C_Y_CTR;
      dx_q     <= DIR_POS;
      dy_q     <= DIR_POS;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      miss_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      cnt_q    <= cnt_d;
      valid_q  <= (state_d != IDLE);
      miss_q   <= (state_d == MISS);
      busy_q   <= (state_d == MOVE_X) || (state_d == MOVE_Y) || (state_d == MISS);
    end
  end

  assign ball_x     = ball_x_q;
  assign ball_y     = ball_y_q;
  assign ball_valid = valid_q;
  assign miss       = miss_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_ball_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_pong_ball_ctrl
// Brief  : Directed self-checking bench for pong_ball_ctrl.
// Rev    : 1.0
// ============================================================================
module tb_pong_ball_ctrl;

  logic       pix_clk   = 1'b0;
  logic       rst_pix_n = 1'b0;
  logic       frame     = 1'b0;
  logic       start     = 1'b0;
  logic [9:0] paddle_y  = 10'd0;
  logic [9:0] ball_x, ball_y;
  logic       ball_valid, miss, busy;

  int checks = 0;
  int errors = 0;
  int busy_cycles = 0;
  int miss_cycles = 0;
  bit track = 1'b0;

  pong_ball_ctrl dut (
    .pix_clk(pix_clk), .rst_pix_n(rst_pix_n), .frame(frame), .start(start),
    .paddle_y(paddle_y), .ball_x(ball_x), .ball_y(ball_y),
    .ball_valid(ball_valid), .miss(miss), .busy(busy)
  );

  always #5 pix_clk = ~pix_clk;

  always @(negedge pix_clk) begin
    if (busy) busy_cycles++;
    if (miss) miss_cycles++;
  end

  task automatic do_reset();
    rst_pix_n = 1'b0;
    frame = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge pix_clk);
    rst_pix_n = 1'b1;
    @(negedge pix_clk);
  endtask

  task automatic do_frame();
    if (track) paddle_y = (ball_y >= 10'd28) ? ball_y - 10'd28 : 10'd0;
    @(negedge pix_clk) frame = 1'b1;
    @(negedge pix_clk) frame = 1'b0;
    repeat (3) @(negedge pix_clk);
  endtask

  task automatic do_start();
    @(negedge pix_clk) start = 1'b1;
    @(negedge pix_clk) start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    busy_cycles = 0;
    checks++;
    if (ball_x !== 10'd316 || ball_y !== 10'd236) begin
      errors++; $display("FAIL reset_pos got %0d,%0d exp 316,236", ball_x, ball_y);
    end
    checks++;
    if (ball_valid !== 1'b0 || miss !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_flags got v%0b m%0b b%0b exp 000", ball_valid, miss, busy);
    end
    repeat (10) do_frame();
    checks++;
    if (ball_x !== 10'd316 || ball_y !== 10'd236 || ball_valid !== 1'b0) begin
      errors++; $display("FAIL idle_frames got %0d,%0d v%0b exp 316,236 v0", ball_x, ball_y, ball_valid);
    end
    checks++;
    if (busy_cycles !== 0) begin
      errors++; $display("FAIL idle_busy got %0d exp 0", busy_cycles);
    end
  endtask

  task automatic test_serve();
    do_reset();
    do_start();
    checks++;
    if (ball_valid !== 1'b1) begin
      errors++; $display("FAIL serve_valid got %0b exp 1", ball_valid);
    end
    busy_cycles = 0;
    repeat (60) do_frame();
    checks++;
    if (ball_x !== 10'd316 || ball_y !== 10'd236 || busy_cycles !== 0) begin
      errors++; $display("FAIL serve_hold got %0d,%0d busy%0d exp 316,236 busy0", ball_x, ball_y, busy_cycles);
    end
    @(negedge pix_clk) frame = 1'b1;
    @(negedge pix_clk) frame = 1'b0;
    checks++;
    if (ball_x !== 10'd316 || busy !== 1'b1) begin
      errors++; $display("FAIL move_n got x%0d b%0b exp x316 b1", ball_x, busy);
    end
    @(negedge pix_clk);
    checks++;
    if (ball_x !== 10'd318 || ball_y !== 10'd236) begin
      errors++; $display("FAIL move_n1 got %0d,%0d exp 318,236", ball_x, ball_y);
    end
    @(negedge pix_clk);
    checks++;
    if (ball_y !== 10'd238 || busy !== 1'b0) begin
      errors++; $display("FAIL move_n2 got y%0d b%0b exp y238 b0", ball_y, busy);
    end
    repeat (3) @(negedge pix_clk);
    checks++;
    if (busy_cycles !== 2) begin
      errors++; $display("FAIL busy_len got %0d exp 2", busy_cycles);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    do_start();
    repeat (60) do_frame();
    track = 1'b1;
    miss_cycles = 0;
    for (int m = 1; m <= 463; m++) begin
      do_frame();
      if (m == 118) begin
        checks++;
        if (ball_y !== 10'd472) begin errors++; $display("FAIL y_clamp got %0d exp 472", ball_y); end
      end
      if (m == 119) begin
        checks++;
        if (ball_y !== 10'd470) begin errors++; $display("FAIL y_flip got %0d exp 470", ball_y); end
      end
      if (m == 158) begin
        checks++;
        if (ball_x !== 10'd632) begin errors++; $display("FAIL x_clamp got %0d exp 632", ball_x); end
      end
      if (m == 159) begin
        checks++;
        if (ball_x !== 10'd630) begin errors++; $display("FAIL x_flip got %0d exp 630", ball_x); end
      end
      if (m == 354) begin
        checks++;
        if (ball_y !== 10'd0) begin errors++; $display("FAIL y_top got %0d exp 0", ball_y); end
      end
      if (m == 462) begin
        checks++;
        if (ball_x !== 10'd24 || ball_y !== 10'd216) begin
          errors++; $display("FAIL paddle_hit got %0d,%0d exp 24,216", ball_x, ball_y);
        end
      end
      if (m == 463) begin
        checks++;
        if (ball_x !== 10'd26 || ball_y !== 10'd218) begin
          errors++; $display("FAIL after_hit got %0d,%0d exp 26,218", ball_x, ball_y);
        end
      end
    end
    track = 1'b0;
    checks++;
    if (miss_cycles !== 0) begin errors++; $display("FAIL hit_no_miss got %0d exp 0", miss_cycles); end
  endtask

  task automatic test_miss();
    do_reset();
    paddle_y = 10'd400;
    do_start();
    repeat (60) do_frame();
    miss_cycles = 0;
    repeat (461) do_frame();
    checks++;
    if (ball_x !== 10'd26 || ball_y !== 10'd214 || miss_cycles !== 0) begin
      errors++; $display("FAIL pre_miss got %0d,%0d m%0d exp 26,214 m0", ball_x, ball_y, miss_cycles);
    end
    @(negedge pix_clk) frame = 1'b1;
    @(negedge pix_clk) frame = 1'b0;
    @(negedge pix_clk);
    checks++;
    if (miss !== 1'b1 || busy !== 1'b1 || ball_x !== 10'd26) begin
      errors++; $display("FAIL miss_pulse got m%0b b%0b x%0d exp m1 b1 x26", miss, busy, ball_x);
    end
    @(negedge pix_clk);
    checks++;
    if (miss !== 1'b0 || ball_x !== 10'd316 || ball_y !== 10'd236) begin
      errors++; $display("FAIL recentre got m%0b %0d,%0d exp m0 316,236", miss, ball_x, ball_y);
    end
    repeat (3) @(negedge pix_clk);
    checks++;
    if (miss_cycles !== 1) begin errors++; $display("FAIL miss_len got %0d exp 1", miss_cycles); end
    repeat (60) do_frame();
    checks++;
    if (ball_x !== 10'd316 || ball_y !== 10'd236) begin
      errors++; $display("FAIL reserve_hold got %0d,%0d exp 316,236", ball_x, ball_y);
    end
    do_frame();
    checks++;
    if (ball_x !== 10'd318 || ball_y !== 10'd238) begin
      errors++; $display("FAIL reserve_move got %0d,%0d exp 318,238", ball_x, ball_y);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    do_start();
    repeat (60) do_frame();
    @(negedge pix_clk) frame = 1'b1;
    @(negedge pix_clk) frame = 1'b0;
    @(negedge pix_clk);
    #2 rst_pix_n = 1'b0;
    #1;
    checks++;
    if (ball_x !== 10'd316 || ball_y !== 10'd236 || ball_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL async_rst got %0d,%0d v%0b b%0b exp 316,236 v0 b0", ball_x, ball_y, ball_valid, busy);
    end
    @(negedge pix_clk) rst_pix_n = 1'b1;
    repeat (2) do_frame();
    checks++;
    if (ball_valid !== 1'b0 || ball_x !== 10'd316) begin
      errors++; $display("FAIL rst_idle got v%0b x%0d exp v0 x316", ball_valid, ball_x);
    end
  endtask

  task automatic test_start_ignore();
    do_reset();
    do_start();
    repeat (61) do_frame();
    do_start();
    do_frame();
    checks++;
    if (ball_x !== 10'd320 || ball_valid !== 1'b1) begin
      errors++; $display("FAIL wait_start got x%0d v%0b exp x320 v1", ball_x, ball_valid);
    end
    do_reset();
    @(negedge pix_clk) begin start = 1'b1; frame = 1'b1; end
    @(negedge pix_clk) begin start = 1'b0; frame = 1'b0; end
    checks++;
    if (ball_valid !== 1'b1) begin errors++; $display("FAIL start_frame got v%0b exp v1", ball_valid); end
    repeat (60) do_frame();
    checks++;
    if (ball_x !== 10'd316) begin errors++; $display("FAIL start_frame_hold got x%0d exp 316", ball_x); end
    do_frame();
    checks++;
    if (ball_x !== 10'd318) begin errors++; $display("FAIL start_frame_move got x%0d exp 318", ball_x); end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_bounce();
    test_miss();
    test_async_reset();
    test_start_ignore();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
